// File: rtl/remex_link.sv
// Generic circular FIFO: registered pointers/count, read data combinational from the head.
// Push when full is dropped unless paired with a pop; empty push+pop passes the word through.
module remex_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);
    assign pop_dat = empty ? push_dat : mem[rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Wishbone 16-bit slave bridging CPU registers to an 8N1 serial link via TX/RX FIFOs.
// ack one clock after strobe (every second cycle back-to-back); TX drops on full FIFO, RX drops on full FIFO.
module remex_link #(
    parameter logic [15:0] DIV_RESET  = 16'd7,
    parameter int          DEPTH_LOG2 = 2
) (
    input  logic        clk_i,
    input  logic        reset_in,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [1:0]  sel_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    output logic        ack_o,
    output logic        tx_o,
    input  logic        rx_i
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic        access;
    logic        req_we;
    logic [1:0]  req_adr;
    logic [1:0]  req_sel;
    logic [15:0] req_dat;
    logic        rx_pop_pend;
    logic [15:0] rd_mux;
    logic [15:0] status;
    logic [15:0] div;
    logic        rx_ovf, tx_ovf, frame_err;

    logic        wr_stb, tx_push, rx_pop, st_clr;
    logic        tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic        rx_push, rx_full, rx_empty;
    logic [7:0]  rx_head;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_timer, tx_timer_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_o_n;

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_timer, rx_timer_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_meta, rx_s, rx_prev;
    logic        rx_ovf_set, ferr_set;

    // Bus request is captured on the strobe edge; its side effects land in the ack cycle.
    assign access  = cyc_i & stb_i & ~ack_o;
    assign wr_stb  = ack_o & req_we;
    assign tx_push = wr_stb & (req_adr == 2'd0) & req_sel[0];
    assign st_clr  = wr_stb & (req_adr == 2'd1) & req_sel[0];
    assign rx_pop  = ack_o & rx_pop_pend;

    assign status = {10'd0, frame_err, tx_ovf, rx_ovf,
                     (tx_state == TX_IDLE) & tx_empty, tx_full, ~rx_empty};

    always_comb begin
        rd_mux = 16'd0;
        case (adr_i)
            2'd0:    if (!rx_empty) rd_mux = {8'h00, rx_head};
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = div;
            default: rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            ack_o       <= 1'b0;
            dat_o       <= 16'd0;
            req_we      <= 1'b0;
            req_adr     <= 2'd0;
            req_sel     <= 2'd0;
            req_dat     <= 16'd0;
            rx_pop_pend <= 1'b0;
        end else begin
            ack_o       <= access;
            dat_o       <= (access & ~we_i) ? rd_mux : 16'd0;
            rx_pop_pend <= access & ~we_i & (adr_i == 2'd0) & ~rx_empty;
            if (access) begin
                req_we  <= we_i;
                req_adr <= adr_i;
                req_sel <= sel_i;
                req_dat <= dat_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            div       <= DIV_RESET;
            rx_ovf    <= 1'b0;
            tx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_stb && req_adr == 2'd2) begin
                if (req_sel[0]) div[7:0]  <= req_dat[7:0];
                if (req_sel[1]) div[15:8] <= req_dat[15:8];
            end
            // A new error event wins over a clear issued in the same cycle.
            rx_ovf    <= rx_ovf_set | (rx_ovf & ~(st_clr & req_dat[3]));
            tx_ovf    <= (tx_push & tx_full & ~tx_pop) | (tx_ovf & ~(st_clr & req_dat[4]));
            frame_err <= ferr_set | (frame_err & ~(st_clr & req_dat[5]));
        end
    end

    remex_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .core_clk (clk_i),
        .arst_n   (reset_in),
        .push     (tx_push),
        .push_dat (req_dat[7:0]),
        .pop      (tx_pop),
        .pop_dat  (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    remex_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .core_clk (clk_i),
        .arst_n   (reset_in),
        .push     (rx_push),
        .push_dat (rx_shift_n),
        .pop      (rx_pop),
        .pop_dat  (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            tx_state <= TX_IDLE;
            tx_timer <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            tx_o     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_timer <= tx_timer_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_o     <= tx_o_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_timer_n = tx_timer;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_timer_n = div;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_timer == 16'd0) begin
                    tx_state_n = TX_DATA;
                    tx_timer_n = div;
                    tx_bit_n   = 3'd0;
                end else begin
                    tx_timer_n = tx_timer - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_timer == 16'd0) begin
                    tx_timer_n = div;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_timer_n = tx_timer - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_timer == 16'd0) tx_state_n = TX_IDLE;
                else                   tx_timer_n = tx_timer - 16'd1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // Line level is registered from the next state so tx_o is glitch-free.
        case (tx_state_n)
            TX_START: tx_o_n = 1'b0;
            TX_DATA:  tx_o_n = tx_shift_n[0];
            default:  tx_o_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_timer <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_meta  <= rx_i;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_state <= rx_state_n;
            rx_timer <= rx_timer_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_timer_n = rx_timer;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_n = RX_START;
                    // (DIV+1)/2 clocks to mid start bit, expressed as a reload value.
                    rx_timer_n = (div - 16'd1) >> 1;
                end
            end
            RX_START: begin
                if (rx_timer == 16'd0) begin
                    if (rx_s) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_timer_n = div;
                        rx_bit_n   = 3'd0;
                    end
                end else begin
                    rx_timer_n = rx_timer - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_timer == 16'd0) begin
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_timer_n = div;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_timer_n = rx_timer - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_timer == 16'd0) begin
                    if (rx_s) begin
                        rx_push    = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        rx_state_n = RX_WAIT;
                    end
                end else begin
                    rx_timer_n = rx_timer - 16'd1;
                end
            end
            RX_WAIT: begin
                if (rx_s) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
        rx_ovf_set = rx_push & rx_full & ~rx_pop;
    end
endmodule

// File: tb/tb_remex_link.sv
// Directed bench for remex_link: register access, TX waveform, loopback RX, error flags, bus timing.
module tb_remex_link;
    logic        clk;
    logic        reset_n;
    logic        cyc, stb, we;
    logic [1:0]  adr, sel;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic        ack;
    logic        tx;
    logic        rx_drv;
    logic        loop;
    logic        rx_line;

    int n_checks = 0;
    int n_fail   = 0;

    assign rx_line = loop ? tx : rx_drv;

    remex_link #(.DIV_RESET(16'd7), .DEPTH_LOG2(2)) dut (
        .clk_i    (clk),
        .reset_in (reset_n),
        .cyc_i    (cyc),
        .stb_i    (stb),
        .we_i     (we),
        .adr_i    (adr),
        .sel_i    (sel),
        .dat_i    (wdat),
        .dat_o    (rdat),
        .ack_o    (ack),
        .tx_o     (tx),
        .rx_i     (rx_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [1:0] s, input logic [15:0] d);
        logic got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; wdat = d;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        check("wr_ack", {15'd0, got}, 16'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        logic got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 2'b11;
        got = 1'b0;
        d = 16'hxxxx;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                d = rdat;
            end
        end
        check("rd_ack", {15'd0, got}, 16'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send_bit(input logic v);
        rx_drv = v;
        repeat (4) @(negedge clk);
    endtask

    // Drives one 8N1 frame at DIV=3 (4 clocks per bit) followed by an idle bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    logic [15:0] r;
    logic [9:0]  tx_pat;

    initial begin
        reset_n = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 2'd0; sel = 2'd0; wdat = 16'd0;
        rx_drv = 1'b1; loop = 1'b0;
        tx_pat = 10'b1101001010;

        // Power-on reset
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {15'd0, tx}, 16'd1);
        check("rst_ack", {15'd0, ack}, 16'd0);
        check("rst_dat", rdat, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        bus_read(2'd1, r); check("rst_status", r, 16'h0004);
        @(posedge clk); #1;
        check("dat_idle_zero", rdat, 16'd0);
        check("ack_idle_zero", {15'd0, ack}, 16'd0);
        bus_read(2'd2, r); check("rst_div", r, 16'h0007);

        // Asynchronous reset in the middle of a frame
        bus_write(2'd0, 2'b01, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        check("tx_midframe_low", {15'd0, tx}, 16'd0);
        #2 reset_n = 1'b0;
        #1;
        check("tx_async_reset", {15'd0, tx}, 16'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, r); check("midrst_status", r, 16'h0004);
        bus_read(2'd2, r); check("midrst_div", r, 16'h0007);

        // Transmit 0xA5 at DIV=3: each line state lasts exactly 4 clocks
        bus_write(2'd2, 2'b11, 16'd3);
        bus_read(2'd2, r); check("div_rd", r, 16'h0003);
        bus_write(2'd0, 2'b01, 16'h00A5);
        @(posedge clk); #1;
        check("tx_pre_start", {15'd0, tx}, 16'd1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("tx_bit", {15'd0, tx}, {15'd0, tx_pat[i / 4]});
        end
        @(posedge clk); #1;
        check("tx_after_frame", {15'd0, tx}, 16'd1);
        bus_read(2'd1, r); check("tx_idle_status", r, 16'h0004);

        // TX overflow at DIV=100
        do_reset();
        bus_write(2'd2, 2'b11, 16'd100);
        for (int i = 1; i <= 5; i++) bus_write(2'd0, 2'b01, 16'(i));
        bus_read(2'd1, r); check("txfull_no_ovf", r, 16'h0002);
        bus_write(2'd0, 2'b01, 16'h0006);
        bus_read(2'd1, r); check("txovf_set", r, 16'h0012);
        bus_write(2'd1, 2'b01, 16'h0010);
        bus_read(2'd1, r); check("txovf_clear", r, 16'h0002);

        // Loopback of two bytes at DIV=3
        do_reset();
        bus_write(2'd2, 2'b11, 16'd3);
        loop = 1'b1;
        bus_write(2'd0, 2'b01, 16'h003C);
        bus_write(2'd0, 2'b01, 16'h00FF);
        repeat (120) @(posedge clk);
        bus_read(2'd0, r); check("loop_rd0", r, 16'h003C);
        bus_read(2'd0, r); check("loop_rd1", r, 16'h00FF);
        bus_read(2'd0, r); check("loop_rd_empty", r, 16'h0000);
        bus_read(2'd1, r); check("loop_status", r, 16'h0004);
        loop = 1'b0;

        // One-clock glitch is rejected
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        repeat (20) @(posedge clk);
        bus_read(2'd1, r); check("glitch_status", r, 16'h0004);

        // Frame with a low stop bit
        send_frame(8'h5A, 1'b0);
        repeat (5) @(posedge clk);
        bus_read(2'd1, r); check("ferr_status", r, 16'h0024);
        bus_read(2'd0, r); check("ferr_no_data", r, 16'h0000);
        bus_write(2'd1, 2'b01, 16'h0020);
        bus_read(2'd1, r); check("ferr_clear", r, 16'h0004);

        // Five frames without reads overflow the 4-entry RX FIFO
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (10) @(posedge clk);
        bus_read(2'd1, r); check("rxovf_status", r, 16'h000D);
        bus_read(2'd0, r); check("rxovf_rd0", r, 16'h0011);
        bus_read(2'd0, r); check("rxovf_rd1", r, 16'h0022);
        bus_read(2'd0, r); check("rxovf_rd2", r, 16'h0033);
        bus_read(2'd0, r); check("rxovf_rd3", r, 16'h0044);
        bus_read(2'd0, r); check("rxovf_rd_empty", r, 16'h0000);
        bus_read(2'd1, r); check("rxovf_sticky", r, 16'h000C);
        bus_write(2'd1, 2'b01, 16'h0008);
        bus_read(2'd1, r); check("rxovf_clear", r, 16'h0004);

        // Strobe held for four cycles: ack every second cycle, two pushes
        do_reset();
        bus_write(2'd2, 2'b11, 16'd3);
        loop = 1'b1;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; sel = 2'b01; wdat = 16'h0041;
        #1;
        check("held_ack0", {15'd0, ack}, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check("held_ack", {15'd0, ack}, 16'(i % 2));
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (120) @(posedge clk);
        bus_read(2'd0, r); check("held_rd0", r, 16'h0041);
        bus_read(2'd0, r); check("held_rd1", r, 16'h0041);
        bus_read(2'd0, r); check("held_rd_empty", r, 16'h0000);
        loop = 1'b0;

        // Address 3 is inert
        bus_write(2'd3, 2'b11, 16'hFFFF);
        bus_read(2'd3, r); check("adr3_read", r, 16'h0000);
        bus_read(2'd2, r); check("adr3_div_intact", r, 16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
